sd_bmp_load_ctrl: RTL and testbench

- Consumes the decoded UDP command (write channel select plus SD-card BMP start address) and moves one image from the SD card into the SDRAM write port.
- Issues sequential sector reads to the SD-card controller, forwards the 16-bit read data to the SDRAM write FIFO, and returns a one-cycle write_finish pulse to the command stage.
- Sits between the command decoder and the SD-card/SDRAM controllers.

---
 rtl/sd_bmp_pkg.sv | 17 +
 rtl/sd_bmp_load_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sd_bmp_load_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_bmp_pkg.sv
// Shared types and constants for the SD-card BMP loader.
package sd_bmp_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_INIT = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    XFER      = 3'd4,
    DONE      = 3'd5
  } state_e;

  localparam logic [1:0]  WR_CH_SDCARD  = 2'd2;
  localparam int unsigned SEC_WORDS_DEF = 256;
  localparam int unsigned BMP_HDR_WORDS = 27;

endpackage

// File: rtl/sd_bmp_load_ctrl.sv
// Moves one BMP image from the SD card into the SDRAM write port, one sector
// at a time, and pulses write_finish when the last sector is done.
// Optional build macro: BMP_HEADER_SKIP_EN drops the 27-word BMP header at the
// start of sector 0 (the words are still counted toward the sector length).
module sd_bmp_load_ctrl
  import sd_bmp_pkg::*;
#(
  parameter int unsigned SECTORS_PER_IMG = 1800,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned SEC_WORDS       = SEC_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cmd_write_ch,
  input  logic [ADDR_W-1:0] cmd_start_addr,
  input  logic              sd_init_done,
  output logic              sd_rd_start,
  output logic [ADDR_W-1:0] sd_rd_sec_addr,
  input  logic              sd_rd_busy,
  input  logic              sd_rd_val_en,
  input  logic [15:0]       sd_rd_val_data,
  input  logic              wr_full,
  output logic              wr_en,
  output logic [15:0]       wr_data,
  output logic              load_busy,
  output logic              write_finish,
  output logic              err_flag
);

  localparam int unsigned SEC_CNT_W  = (SECTORS_PER_IMG > 1) ? $clog2(SECTORS_PER_IMG) : 1;
  localparam int unsigned WORD_CNT_W = $clog2(SEC_WORDS + 1);
  localparam logic [SEC_CNT_W-1:0]  SEC_LAST   = SEC_CNT_W'(SECTORS_PER_IMG - 1);
  localparam logic [WORD_CNT_W-1:0] WORDS_FULL = WORD_CNT_W'(SEC_WORDS);

  state_e                  state_q, state_d;
  logic                    ch_sd_q;
  logic                    busy_q;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [SEC_CNT_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]       addr_d;
  logic                    wr_en_d;
  logic [15:0]             wr_data_d;
  logic                    err_d;
  logic                    trig;
  logic                    busy_fall;
  logic                    hdr_skip;

  assign trig      = (cmd_write_ch == WR_CH_SDCARD) && !ch_sd_q;
  assign busy_fall = busy_q && !sd_rd_busy;

`ifdef BMP_HEADER_SKIP_EN
  localparam logic [WORD_CNT_W-1:0] HDR_WORDS = WORD_CNT_W'(BMP_HDR_WORDS);
  assign hdr_skip = (sec_cnt_q == '0) && (word_cnt_q < HDR_WORDS);
`else
  assign hdr_skip = 1'b0;
`endif

  // Previous-cycle copies for the trigger and busy edge detectors.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_sd_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ch_sd_q <= (cmd_write_ch == WR_CH_SDCARD);
      busy_q  <= sd_rd_busy;
    end
  end

  // Next-state, counter and output-data logic.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    sec_cnt_d  = sec_cnt_q;
    word_cnt_d = word_cnt_q;
    addr_d     = sd_rd_sec_addr;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data;
    err_d      = err_flag;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d    = WAIT_INIT;
          base_d     = cmd_start_addr;
          sec_cnt_d  = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      WAIT_INIT: begin
        if (sd_init_done) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (sd_rd_busy) state_d = XFER;
      end
      XFER: begin
        // Every valid word is counted; only words with FIFO room are written.
        if (sd_rd_val_en) begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
          wr_data_d  = sd_rd_val_data;
          if (wr_full) begin
            err_d = 1'b1;
          end else if (!hdr_skip) begin
            wr_en_d = 1'b1;
          end
        end
        // End of sector: the count includes a word arriving on this same cycle.
        if (busy_fall) begin
          if (word_cnt_d != WORDS_FULL) err_d = 1'b1;
          word_cnt_d = '0;
          if (sec_cnt_q == SEC_LAST) begin
            state_d = DONE;
          end else begin
            sec_cnt_d = sec_cnt_q + SEC_CNT_W'(1);
            state_d   = ISSUE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Sector address is loaded on entry to ISSUE and held until the next one.
    if (state_d == ISSUE) addr_d = base_d + ADDR_W'(sec_cnt_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      base_q         <= '0;
      sec_cnt_q      <= '0;
      word_cnt_q     <= '0;
      sd_rd_start    <= 1'b0;
      sd_rd_sec_addr <= '0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
      load_busy      <= 1'b0;
      write_finish   <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      sec_cnt_q      <= sec_cnt_d;
      word_cnt_q     <= word_cnt_d;
      sd_rd_start    <= (state_d == ISSUE);
      sd_rd_sec_addr <= addr_d;
      wr_en          <= wr_en_d;
      wr_data        <= wr_data_d;
      load_busy      <= (state_d != IDLE);
      write_finish   <= (state_d == DONE);
      err_flag       <= err_d;
    end
  end

endmodule

// File: tb/tb_sd_bmp_load_ctrl.sv
// Self-checking bench for sd_bmp_load_ctrl with a 4-sector image.
module tb_sd_bmp_load_ctrl;

  localparam int unsigned N_SEC     = 4;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned SEC_WORDS = 256;
`ifdef BMP_HEADER_SKIP_EN
  localparam int HDR = 27;
`else
  localparam int HDR = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        cmd_write_ch;
  logic [ADDR_W-1:0] cmd_start_addr;
  logic              sd_init_done;
  logic              sd_rd_start;
  logic [ADDR_W-1:0] sd_rd_sec_addr;
  logic              sd_rd_busy;
  logic              sd_rd_val_en;
  logic [15:0]       sd_rd_val_data;
  logic              wr_full;
  logic              wr_en;
  logic [15:0]       wr_data;
  logic              load_busy;
  logic              write_finish;
  logic              err_flag;

  sd_bmp_load_ctrl #(
    .SECTORS_PER_IMG(N_SEC),
    .ADDR_W         (ADDR_W),
    .SEC_WORDS      (SEC_WORDS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_write_ch  (cmd_write_ch),
    .cmd_start_addr(cmd_start_addr),
    .sd_init_done  (sd_init_done),
    .sd_rd_start   (sd_rd_start),
    .sd_rd_sec_addr(sd_rd_sec_addr),
    .sd_rd_busy    (sd_rd_busy),
    .sd_rd_val_en  (sd_rd_val_en),
    .sd_rd_val_data(sd_rd_val_data),
    .wr_full       (wr_full),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .load_busy     (load_busy),
    .write_finish  (write_finish),
    .err_flag      (err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] start_addr;
    int                init_delay;
    int                retrig_sec;
    int                full_sec;
    int                full_first;
    int                full_cnt;
    int                short_sec;
    int                short_words;
    int                exp_beats;
    logic              exp_err;
  } vec_t;

  vec_t              vecs[4];
  int                n_vec = 0;
  int                n_err = 0;
  int                beats, starts, finishes;
  logic [15:0]       exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard for write data and sector addresses.
  always @(negedge clk) begin
    logic [15:0]       ed;
    logic [ADDR_W-1:0] ea;
    if (!reset) begin
      if (wr_en) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("wr_en_unexpected", 64'(1), 64'(0));
        end else begin
          ed = exp_q.pop_front();
          check("wr_data", 64'(wr_data), 64'(ed));
        end
      end
      if (sd_rd_start) begin
        starts++;
        if (addr_q.size() == 0) begin
          check("sd_rd_start_unexpected", 64'(1), 64'(0));
        end else begin
          ea = addr_q.pop_front();
          check("sd_rd_sec_addr", 64'(sd_rd_sec_addr), 64'(ea));
        end
      end
      if (write_finish) finishes++;
    end
  end

  // SD-card model for one sector; abort_at >= 0 stops mid-sector with busy still high.
  task automatic run_sector(input int s, input vec_t v, input int abort_at);
    int  n;
    bit  got;
    logic [15:0] d;
    n   = (s == v.short_sec) ? v.short_words : int'(SEC_WORDS);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (sd_rd_start) got = 1'b1;
      else tick();
    end
    check("sd_rd_start_seen", 64'(got), 64'(1));
    tick();
    sd_rd_busy = 1'b1;
    tick();
    if (s == v.retrig_sec) begin
      cmd_write_ch = 2'd0;
      tick();
      cmd_write_ch = 2'd2;
      tick();
    end
    for (int w = 0; w < n; w++) begin
      if (w == abort_at) return;
      d = 16'($urandom);
      sd_rd_val_en   = 1'b1;
      sd_rd_val_data = d;
      wr_full = (s == v.full_sec) && (w >= v.full_first) && (w < v.full_first + v.full_cnt);
      if (!wr_full && !(s == 0 && w < HDR)) exp_q.push_back(d);
      tick();
    end
    sd_rd_val_en = 1'b0;
    wr_full      = 1'b0;
    tick();
    sd_rd_busy = 1'b0;
    tick();
  endtask

  task automatic start_img(input vec_t v);
    beats = 0; starts = 0; finishes = 0;
    exp_q.delete();
    addr_q.delete();
    for (int s = 0; s < int'(N_SEC); s++) addr_q.push_back(v.start_addr + ADDR_W'(s));
    cmd_start_addr = v.start_addr;
    sd_init_done   = (v.init_delay == 0);
    cmd_write_ch   = 2'd0;
    tick();
    cmd_write_ch = 2'd2;
    tick();
    check("err_cleared_on_trigger", 64'(err_flag), 64'(0));
    check("load_busy_after_trigger", 64'(load_busy), 64'(1));
    if (v.init_delay > 0) begin
      repeat (v.init_delay) tick();
      check("no_start_before_init", 64'(starts), 64'(0));
      sd_init_done = 1'b1;
    end
  endtask

  task automatic run_img(input vec_t v);
    bit got;
    start_img(v);
    for (int s = 0; s < int'(N_SEC); s++) run_sector(s, v, -1);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (write_finish) got = 1'b1;
      else tick();
    end
    check("write_finish_seen", 64'(got), 64'(1));
    tick();
    tick();
    check("sd_rd_start_count", 64'(starts), 64'(N_SEC));
    check("wr_en_beats", 64'(beats), 64'(v.exp_beats));
    check("write_finish_count", 64'(finishes), 64'(1));
    check("err_flag_end", 64'(err_flag), 64'(v.exp_err));
    check("load_busy_end", 64'(load_busy), 64'(0));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sd_rd_start"},    64'(sd_rd_start), 64'(0));
    check({tag, "_sd_rd_sec_addr"}, 64'(sd_rd_sec_addr), 64'(0));
    check({tag, "_wr_en"},          64'(wr_en), 64'(0));
    check({tag, "_wr_data"},        64'(wr_data), 64'(0));
    check({tag, "_load_busy"},      64'(load_busy), 64'(0));
    check({tag, "_write_finish"},   64'(write_finish), 64'(0));
    check({tag, "_err_flag"},       64'(err_flag), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t va;
    // start, init_delay, retrig, full sec/first/cnt, short sec/words, beats, err
    vecs[0] = '{32'd8484,      0, -1, -1,  0, 0, -1,   0, 1024 - HDR, 1'b0};
    vecs[1] = '{32'd1000,     50,  1, -1,  0, 0, -1,   0, 1024 - HDR, 1'b0};
    vecs[2] = '{32'hFFFF_FFFE,  0, -1,  1, 10, 3, -1,   0, 1021 - HDR, 1'b1};
    vecs[3] = '{32'd500,        0, -1, -1,  0, 0,  2, 200,  968 - HDR, 1'b1};

    reset = 1'b1; cmd_write_ch = 2'd0; cmd_start_addr = '0; sd_init_done = 1'b0;
    sd_rd_busy = 1'b0; sd_rd_val_en = 1'b0; sd_rd_val_data = '0; wr_full = 1'b0;
    beats = 0; starts = 0; finishes = 0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) run_img(vecs[k]);

    // Reset in the middle of sector 1 aborts without a finish pulse.
    va = '{32'd777, 0, -1, 0, 5, 2, -1, 0, 0, 1'b1};
    start_img(va);
    run_sector(0, va, -1);
    run_sector(1, va, 100);
    check("err_before_reset", 64'(err_flag), 64'(1));
    reset = 1'b1; sd_rd_val_en = 1'b0; cmd_write_ch = 2'd0;
    tick();
    check_all_zero("midxfer_reset");
    exp_q.delete();
    addr_q.delete();
    sd_rd_busy = 1'b0;
    reset = 1'b0;
    repeat (20) tick();
    check("no_finish_after_abort", 64'(finishes), 64'(0));
    check("idle_after_abort", 64'(load_busy), 64'(0));

    va = '{32'd4242, 0, -1, -1, 0, 0, -1, 0, 1024 - HDR, 1'b0};
    run_img(va);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
